// File: rtl/patch_cam_ctrl_if.sv
// Config-bus write port and CAM write port of the patch CAM sequencer.
interface patch_cam_ctrl_if;
  logic [15:0] config_addr;
  logic [15:0] config_data;
  logic        config_strobe;
  logic [22:0] cam_din;
  logic [22:0] cam_data_mask;
  logic        cam_we;
  logic [5:0]  cam_wr_addr;
  logic        cam_busy;

  modport master (output config_addr, config_data, config_strobe, cam_busy,
                  input  cam_din, cam_data_mask, cam_we, cam_wr_addr);
  modport slave  (input  config_addr, config_data, config_strobe, cam_busy,
                  output cam_din, cam_data_mask, cam_we, cam_wr_addr);
endinterface

// File: rtl/patch_cam_ctrl.sv
// Patch CAM write sequencer: staging registers, one-deep request slot, clear-all sweep.
// Optional per-entry valid map is built when PATCH_CAM_VALID_EN is defined.
module patch_cam_ctrl #(
  parameter int unsigned WRITE_CYCLES = 16,
  parameter logic [22:0] CLEAR_ADDR   = 23'h7FFFFF,
  parameter logic [15:0] BASE_ADDR    = 16'h7000
) (
  input  logic            mclk,
  input  logic            reset,
  patch_cam_ctrl_if.slave bus,
  output logic            lookup_enable,
  output logic            ctrl_busy,
  output logic            overrun,
  output logic [15:0]     write_count,
  output logic [63:0]     entry_valid
);
  localparam int unsigned AW = 23;
  localparam int unsigned IW = 6;
  localparam int unsigned NE = 64;
  localparam int unsigned CW = $clog2(WRITE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WRITE_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLR_ISSUE, CLR_WAIT} state_e;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [AW-1:0] mask;
    logic [IW-1:0] idx;
  } req_t;

  state_e        state_q, state_d;
  logic [AW-1:0] stg_addr_q, stg_addr_d, stg_mask_q, stg_mask_d;
  req_t          cur_q, cur_d, pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d, clr_req_q, clr_req_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] din_q, din_d, dmask_q, dmask_d;
  logic          we_q, we_d;
  logic [IW-1:0] waddr_q, waddr_d;
  logic          lookup_q, lookup_d, busy_q, busy_d, overrun_q, overrun_d;
  logic [15:0]   wcount_q, wcount_d;
`ifdef PATCH_CAM_VALID_EN
  logic [NE-1:0] valid_q, valid_d;
`endif

  logic [15:0] reg_off_c;
  logic        wr_alo_c, wr_ahi_c, wr_mlo_c, wr_mhi_c, trig_c, ctl_c, trig_used_c;
  req_t        new_req_c;

  // Register decode relative to the config base
  assign reg_off_c = bus.config_addr - BASE_ADDR;
  assign wr_alo_c  = bus.config_strobe && (reg_off_c == 16'd0);
  assign wr_ahi_c  = bus.config_strobe && (reg_off_c == 16'd1);
  assign wr_mlo_c  = bus.config_strobe && (reg_off_c == 16'd2);
  assign wr_mhi_c  = bus.config_strobe && (reg_off_c == 16'd3);
  assign trig_c    = bus.config_strobe && (reg_off_c == 16'd4);
  assign ctl_c     = bus.config_strobe && (reg_off_c == 16'd5);
  assign new_req_c = '{addr: stg_addr_q, mask: stg_mask_q, idx: bus.config_data[IW-1:0]};

  always_comb begin
    state_d     = state_q;
    stg_addr_d  = stg_addr_q;
    stg_mask_d  = stg_mask_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    clr_req_d   = clr_req_q;
    clr_idx_d   = clr_idx_q;
    cnt_d       = cnt_q;
    din_d       = din_q;
    dmask_d     = dmask_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    overrun_d   = overrun_q;
    wcount_d    = wcount_q;
    trig_used_c = 1'b0;
`ifdef PATCH_CAM_VALID_EN
    valid_d     = valid_q;
`endif

    if (wr_alo_c) stg_addr_d[15:0]  = bus.config_data;
    if (wr_ahi_c) stg_addr_d[22:16] = bus.config_data[6:0];
    if (wr_mlo_c) stg_mask_d[15:0]  = bus.config_data;
    if (wr_mhi_c) stg_mask_d[22:16] = bus.config_data[6:0];

    unique case (state_q)
      IDLE: begin
        if (clr_req_q || (ctl_c && bus.config_data[0])) begin
          state_d   = CLR_ISSUE;
          clr_req_d = 1'b0;
          clr_idx_d = '0;
        end else if (pend_vld_q) begin
          // Slot drains into the active request, so a same-cycle trigger refills it
          cur_d       = pend_q;
          pend_vld_d  = 1'b0;
          state_d     = ISSUE;
        end else if (trig_c) begin
          cur_d       = new_req_c;
          trig_used_c = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        we_d    = 1'b1;
        din_d   = cur_q.addr;
        dmask_d = cur_q.mask;
        waddr_d = cur_q.idx;
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!bus.cam_busy) begin
          wcount_d = wcount_q + 16'd1;
`ifdef PATCH_CAM_VALID_EN
          valid_d[cur_q.idx] = 1'b1;
`endif
          if (clr_req_q) begin
            state_d   = CLR_ISSUE;
            clr_req_d = 1'b0;
            clr_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CLR_ISSUE: begin
        we_d    = 1'b1;
        din_d   = CLEAR_ADDR;
        dmask_d = '0;
        waddr_d = clr_idx_q;
        cnt_d   = CNT_LOAD;
        state_d = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!bus.cam_busy) begin
          wcount_d = wcount_q + 16'd1;
`ifdef PATCH_CAM_VALID_EN
          valid_d[clr_idx_q] = 1'b0;
`endif
          if (clr_idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            clr_idx_d = clr_idx_q + IW'(1);
            state_d   = CLR_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Triggers not consumed directly go to the slot or are dropped
    if (trig_c && !trig_used_c) begin
      if (!pend_vld_d) begin
        pend_d     = new_req_c;
        pend_vld_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Clear request during a single write is deferred to its completion
    if (ctl_c && bus.config_data[0] && (state_q == ISSUE || state_q == WAIT) &&
        (state_d != CLR_ISSUE))
      clr_req_d = 1'b1;
    if (ctl_c && bus.config_data[1]) overrun_d = 1'b0;

    lookup_d = !(state_d == CLR_ISSUE || state_d == CLR_WAIT);
    busy_d   = (state_d != IDLE) || pend_vld_d || clr_req_d;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      stg_addr_q <= '0;
      stg_mask_q <= '0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clr_req_q  <= 1'b0;
      clr_idx_q  <= '0;
      cnt_q      <= '0;
      din_q      <= '0;
      dmask_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      lookup_q   <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      wcount_q   <= '0;
`ifdef PATCH_CAM_VALID_EN
      valid_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      stg_addr_q <= stg_addr_d;
      stg_mask_q <= stg_mask_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clr_req_q  <= clr_req_d;
      clr_idx_q  <= clr_idx_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      dmask_q    <= dmask_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      lookup_q   <= lookup_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      wcount_q   <= wcount_d;
`ifdef PATCH_CAM_VALID_EN
      valid_q    <= valid_d;
`endif
    end
  end

  assign bus.cam_din       = din_q;
  assign bus.cam_data_mask = dmask_q;
  assign bus.cam_we        = we_q;
  assign bus.cam_wr_addr   = waddr_q;
  assign lookup_enable     = lookup_q;
  assign ctrl_busy         = busy_q;
  assign overrun           = overrun_q;
  assign write_count       = wcount_q;
`ifdef PATCH_CAM_VALID_EN
  assign entry_valid = valid_q;
`else
  assign entry_valid = '0;
`endif
endmodule

// File: tb/tb_patch_cam_ctrl.sv
// Directed bench for patch_cam_ctrl: table of single writes plus busy, overrun, sweep and reset sequences.
module tb_patch_cam_ctrl;
  logic        mclk = 1'b0;
  logic        reset;
  logic        lookup_enable, ctrl_busy, overrun;
  logic [15:0] write_count;
  logic [63:0] entry_valid;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  patch_cam_ctrl_if bus ();

  patch_cam_ctrl dut (
    .mclk         (mclk),
    .reset        (reset),
    .bus          (bus.slave),
    .lookup_enable(lookup_enable),
    .ctrl_busy    (ctrl_busy),
    .overrun      (overrun),
    .write_count  (write_count),
    .entry_valid  (entry_valid)
  );

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    logic [22:0] din;
    logic [22:0] mask;
    logic [5:0]  addr;
    int          cyc;
  } pulse_t;
  pulse_t pq[$];

  always @(negedge mclk)
    if (bus.cam_we === 1'b1) pq.push_back('{bus.cam_din, bus.cam_data_mask, bus.cam_wr_addr, cyc});

  typedef struct {
    logic [15:0] alo, ahi, mlo, mhi;
    logic [5:0]  idx;
    logic [22:0] exp_din, exp_mask;
  } vec_t;
  vec_t vecs[4];

  logic [63:0] exp_valid = 64'h0;
  logic [15:0] exp_wc = 16'h0;

  function automatic logic [63:0] valid_exp();
`ifdef PATCH_CAM_VALID_EN
    return exp_valid;
`else
    return 64'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic cfg_write(input logic [15:0] a, input logic [15:0] d);
    bus.config_addr   = a;
    bus.config_data   = d;
    bus.config_strobe = 1'b1;
    tick();
    bus.config_strobe = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm, input int max);
    int n = 0;
    while (ctrl_busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    chk({nm, "_idle"}, 64'(ctrl_busy), 64'h0);
  endtask

  initial begin
    int n;
    int start_cyc;
    int rise_cyc;
    int bad;
    logic found;

    vecs[0] = '{16'h1234, 16'h0040, 16'h000F, 16'h0000, 6'd5,  23'h401234, 23'h00000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'd63, 23'h7FFFFF, 23'h7FFFFF};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'd0,  23'h000000, 23'h000000};
    vecs[3] = '{16'hABCD, 16'h0012, 16'h5A5A, 16'h007F, 6'd42, 23'h12ABCD, 23'h7F5A5A};

    reset = 1'b0;
    bus.config_addr = '0;
    bus.config_data = '0;
    bus.config_strobe = 1'b0;
    bus.cam_busy = 1'b0;
    repeat (3) @(posedge mclk);
    #1 reset = 1'b1;
    tick();

    chk("rst_we", 64'(bus.cam_we), 64'h0);
    chk("rst_addr", 64'(bus.cam_wr_addr), 64'h0);
    chk("rst_din", 64'(bus.cam_din), 64'h0);
    chk("rst_mask", 64'(bus.cam_data_mask), 64'h0);
    chk("rst_lookup", 64'(lookup_enable), 64'h1);
    chk("rst_busy", 64'(ctrl_busy), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);
    chk("rst_wc", 64'(write_count), 64'h0);
    chk("rst_valid", entry_valid, 64'h0);

    // Single writes: latency, payload, pulse width, completion timing
    for (int i = 0; i < 4; i++) begin
      cfg_write(16'h7000, vecs[i].alo);
      cfg_write(16'h7001, vecs[i].ahi);
      cfg_write(16'h7002, vecs[i].mlo);
      cfg_write(16'h7003, vecs[i].mhi);
      cfg_write(16'h7004, 16'(vecs[i].idx));
      chk($sformatf("v%0d_we_early", i), 64'(bus.cam_we), 64'h0);
      tick();
      chk($sformatf("v%0d_we", i), 64'(bus.cam_we), 64'h1);
      chk($sformatf("v%0d_din", i), 64'(bus.cam_din), 64'(vecs[i].exp_din));
      chk($sformatf("v%0d_mask", i), 64'(bus.cam_data_mask), 64'(vecs[i].exp_mask));
      chk($sformatf("v%0d_addr", i), 64'(bus.cam_wr_addr), 64'(vecs[i].idx));
      tick();
      chk($sformatf("v%0d_we_width", i), 64'(bus.cam_we), 64'h0);
      repeat (14) tick();
      chk($sformatf("v%0d_wc_before", i), 64'(write_count), 64'(exp_wc));
      tick();
      exp_wc++;
      exp_valid[vecs[i].idx] = 1'b1;
      chk($sformatf("v%0d_wc_after", i), 64'(write_count), 64'(exp_wc));
      chk($sformatf("v%0d_busy", i), 64'(ctrl_busy), 64'h0);
      chk($sformatf("v%0d_valid", i), entry_valid, valid_exp());
    end

    // cam_busy stretches the wait; queued request keeps its captured staging
    cfg_write(16'h7000, 16'h2222);
    cfg_write(16'h7001, 16'h0003);
    cfg_write(16'h7002, 16'h0001);
    cfg_write(16'h7003, 16'h0000);
    pq.delete();
    bus.cam_busy = 1'b1;
    cfg_write(16'h7004, 16'd7);
    tick();
    chk("busy_first_we", 64'(bus.cam_we), 64'h1);
    chk("busy_first_addr", 64'(bus.cam_wr_addr), 64'd7);
    cfg_write(16'h7004, 16'd6);
    cfg_write(16'h7000, 16'h5555);
    repeat (28) tick();
    chk("busy_held_pulses", 64'(pq.size()), 64'd1);
    chk("busy_held_wc", 64'(write_count), 64'(exp_wc));
    chk("busy_held_busy", 64'(ctrl_busy), 64'h1);
    bus.cam_busy = 1'b0;
    n = 0;
    while (pq.size() < 2 && n < 10) begin
      tick();
      n++;
    end
    chk("busy_second_pulse", 64'(pq.size()), 64'd2);
    if (pq.size() >= 2) begin
      chk("busy_second_addr", 64'(pq[1].addr), 64'd6);
      chk("busy_second_din", 64'(pq[1].din), 64'h032222);
      chk("busy_second_mask", 64'(pq[1].mask), 64'h1);
    end
    wait_idle("busy", 40);
    exp_wc += 16'd2;
    exp_valid[7] = 1'b1;
    exp_valid[6] = 1'b1;
    chk("busy_wc", 64'(write_count), 64'(exp_wc));
    chk("busy_overrun", 64'(overrun), 64'h0);
    chk("busy_valid", entry_valid, valid_exp());

    // Back-to-back triggers overflow the one-deep slot
    pq.delete();
    cfg_write(16'h7004, 16'd1);
    cfg_write(16'h7004, 16'd2);
    cfg_write(16'h7004, 16'd3);
    chk("ovr_set", 64'(overrun), 64'h1);
    wait_idle("ovr", 80);
    chk("ovr_pulses", 64'(pq.size()), 64'd2);
    if (pq.size() == 2) begin
      chk("ovr_addr0", 64'(pq[0].addr), 64'd1);
      chk("ovr_din0", 64'(pq[0].din), 64'h035555);
      chk("ovr_addr1", 64'(pq[1].addr), 64'd2);
    end
    exp_wc += 16'd2;
    exp_valid[1] = 1'b1;
    exp_valid[2] = 1'b1;
    chk("ovr_wc", 64'(write_count), 64'(exp_wc));
    chk("ovr_sticky", 64'(overrun), 64'h1);
    cfg_write(16'h7005, 16'h0002);
    chk("ovr_clear", 64'(overrun), 64'h0);

    // Clear sweep with a single write queued behind it
    cfg_write(16'h7000, 16'h0100);
    cfg_write(16'h7001, 16'h0000);
    cfg_write(16'h7002, 16'h0000);
    cfg_write(16'h7003, 16'h0000);
    pq.delete();
    cfg_write(16'h7005, 16'h0001);
    start_cyc = cyc;
    chk("swp_lookup_fall", 64'(lookup_enable), 64'h0);
    chk("swp_busy", 64'(ctrl_busy), 64'h1);
    found = 1'b0;
    rise_cyc = 0;
    for (int i = 0; i < 1300; i++) begin
      if (i == 100) cfg_write(16'h7004, 16'd9);
      else tick();
      if (lookup_enable === 1'b1) begin
        found = 1'b1;
        rise_cyc = cyc;
        break;
      end
    end
    chk("swp_lookup_rise", 64'(found), 64'h1);
    chk("swp_pulses_at_rise", 64'(pq.size()), 64'd64);
    if (pq.size() >= 64) begin
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        if (pq[i].addr != 6'(i) || pq[i].din != 23'h7FFFFF || pq[i].mask != 23'h0) bad++;
        if (i > 0 && (pq[i].cyc - pq[i-1].cyc) < 16) bad++;
      end
      chk("swp_pulse_content", 64'(bad), 64'h0);
      chk("swp_first_latency", 64'(pq[0].cyc - start_cyc), 64'd1);
      chk("swp_rise_timing", 64'(rise_cyc - pq[63].cyc), 64'd16);
    end
    wait_idle("swp", 40);
    chk("swp_total_pulses", 64'(pq.size()), 64'd65);
    if (pq.size() == 65) begin
      chk("swp_pend_addr", 64'(pq[64].addr), 64'd9);
      chk("swp_pend_din", 64'(pq[64].din), 64'h000100);
      chk("swp_pend_mask", 64'(pq[64].mask), 64'h0);
    end
    exp_wc += 16'd65;
    exp_valid = 64'h200;
    chk("swp_wc", 64'(write_count), 64'(exp_wc));
    chk("swp_valid", entry_valid, valid_exp());
    chk("swp_lookup_end", 64'(lookup_enable), 64'h1);

    // Asynchronous reset while entry 20 is being written
    pq.delete();
    cfg_write(16'h7005, 16'h0001);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (bus.cam_we === 1'b1 && bus.cam_wr_addr == 6'd20) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstm_reach20", 64'(found), 64'h1);
    #2 reset = 1'b0;
    #1;
    chk("rstm_we", 64'(bus.cam_we), 64'h0);
    chk("rstm_lookup", 64'(lookup_enable), 64'h1);
    chk("rstm_wc", 64'(write_count), 64'h0);
    chk("rstm_busy", 64'(ctrl_busy), 64'h0);
    repeat (3) @(posedge mclk);
    #1 reset = 1'b1;
    pq.delete();
    repeat (100) tick();
    chk("rstm_no_pulses", 64'(pq.size()), 64'h0);
    chk("rstm_valid", entry_valid, 64'h0);
    chk("rstm_wc_after", 64'(write_count), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
